logic_exec_stage: RTL and testbench

- Two-stage pipelined logic execute unit for the ARM-style core.
- Sits between decode/operand-read and writeback. Consumes two 32-bit operands plus an opcode, shift type and shift amount.
- Applies the barrel shift to operand B, then performs the data-processing logic op through the team's 32-bit bitwise AND/OR/XOR gate modules.
- Produces a registered result and NZC flags, with valid/ready handshakes on both sides and a synchronous flush.

---
 rtl/logic_exec_stage.sv | 253 +++++++++++++++++++++++++
 tb/tb_logic_exec_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_exec_stage.sv
// logic_exec_stage: two-stage pipelined logic execute unit.
//   Stage 1 barrel-shifts operand B and captures the shifter carry.
//   Stage 2 performs the data-processing logic op and produces NZC flags.
// Ports:
//   clk, rst                   clock, async active-high reset
//   flush                      synchronous pipeline kill
//   in_valid/in_ready          upstream handshake
//   in_op, in_a, in_b          opcode (AND..TEQ) and operands
//   in_shtype, in_shamt        shift type (LSL/LSR/ASR/ROR) and amount
//   in_c, in_setf, in_rd       carry in, S bit, destination tag
//   out_valid/out_ready        downstream handshake
//   out_result, out_rd         result and destination tag
//   out_wr, out_setf           register write enable, flag write enable
//   out_n, out_z, out_c        flag values
module logic_exec_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_shtype,
    input  logic [4:0]       in_shamt,
    input  logic             in_c,
    input  logic             in_setf,
    input  logic [3:0]       in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_rd,
    output logic             out_wr,
    output logic             out_setf,
    output logic             out_n,
    output logic             out_z,
    output logic             out_c
);

    localparam int unsigned OPW = 3;
    localparam int unsigned RDW = 4;

    // Stage 1 registers
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic             s1_c_q, s1_c_d;
    logic [OPW-1:0]   s1_op_q, s1_op_d;
    logic             s1_setf_q, s1_setf_d;
    logic [RDW-1:0]   s1_rd_q, s1_rd_d;

    // Stage 2 (output) registers
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [RDW-1:0]   rd_q, rd_d;
    logic             wr_q, wr_d;
    logic             setf_q, setf_d;
    logic             n_q, n_d;
    logic             z_q, z_d;
    logic             c_q, c_d;

    logic             adv1, adv2;
    logic [WIDTH-1:0] sh_b;
    logic             sh_c;
    logic [4:0]       lsl_idx;
    logic [4:0]       rt_idx;
    logic [WIDTH-1:0] b_n;
    logic [WIDTH-1:0] and_ab, bic_ab, or_ab, xor_ab;
    logic [WIDTH-1:0] logic_res;
    logic             is_test;

    // Pipeline advance: each stage moves when the stage after it can take data
    assign adv2     = !s2_valid_q || out_ready;
    assign adv1     = !s1_valid_q || adv2;
    assign in_ready = adv1 && !flush;

    // Barrel shifter; lsl_idx = 32-n wraps to the bit that falls off the top
    assign lsl_idx = 5'd0 - in_shamt;
    assign rt_idx  = in_shamt - 5'd1;

    always_comb begin
        sh_b = in_b;
        sh_c = in_c;
        if (in_shamt != 5'd0) begin
            unique case (in_shtype)
                2'd0: begin
                    sh_b = in_b << in_shamt;
                    sh_c = in_b[lsl_idx];
                end
                2'd1: begin
                    sh_b = in_b >> in_shamt;
                    sh_c = in_b[rt_idx];
                end
                2'd2: begin
                    sh_b = WIDTH'($signed(in_b) >>> in_shamt);
                    sh_c = in_b[rt_idx];
                end
                default: begin
                    sh_b = (in_b >> in_shamt) | (in_b << lsl_idx);
                    sh_c = in_b[rt_idx];
                end
            endcase
        end
    end

    // Logic terms from the shared gate cells
    assign b_n = ~s1_b_q;

    W_AND32 u_and (.a(s1_a_q), .b(s1_b_q), .y(and_ab));
    W_AND32 u_bic (.a(s1_a_q), .b(b_n),    .y(bic_ab));
    W_OR32  u_or  (.a(s1_a_q), .b(s1_b_q), .y(or_ab));
    W_XOR32 u_xor (.a(s1_a_q), .b(s1_b_q), .y(xor_ab));

    always_comb begin
        logic_res = and_ab;
        unique case (s1_op_q)
            3'd0:    logic_res = and_ab;
            3'd1:    logic_res = xor_ab;
            3'd2:    logic_res = or_ab;
            3'd3:    logic_res = bic_ab;
            3'd4:    logic_res = s1_b_q;
            3'd5:    logic_res = b_n;
            3'd6:    logic_res = and_ab;
            default: logic_res = xor_ab;
        endcase
    end

    // TST/TEQ: compare-only ops, never write Rd, always write flags
    assign is_test = s1_op_q[2] && s1_op_q[1];

    // Next-state for both stages; flush kills valids, payload stays stale
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_c_d     = s1_c_q;
        s1_op_d    = s1_op_q;
        s1_setf_d  = s1_setf_q;
        s1_rd_d    = s1_rd_q;
        s2_valid_d = s2_valid_q;
        res_d      = res_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        setf_d     = setf_q;
        n_d        = n_q;
        z_d        = z_q;
        c_d        = c_q;
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (adv2) begin
                s2_valid_d = s1_valid_q;
                if (s1_valid_q) begin
                    res_d  = logic_res;
                    rd_d   = s1_rd_q;
                    wr_d   = !is_test;
                    setf_d = s1_setf_q || is_test;
                    n_d    = logic_res[WIDTH-1];
                    z_d    = (logic_res == '0);
                    c_d    = s1_c_q;
                end
            end
            if (adv1) begin
                s1_valid_d = in_valid;
                if (in_valid) begin
                    s1_a_d    = in_a;
                    s1_b_d    = sh_b;
                    s1_c_d    = sh_c;
                    s1_op_d   = in_op;
                    s1_setf_d = in_setf;
                    s1_rd_d   = in_rd;
                end
            end
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_c_q     <= 1'b0;
            s1_op_q    <= '0;
            s1_setf_q  <= 1'b0;
            s1_rd_q    <= '0;
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            rd_q       <= '0;
            wr_q       <= 1'b0;
            setf_q     <= 1'b0;
            n_q        <= 1'b0;
            z_q        <= 1'b0;
            c_q        <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_c_q     <= s1_c_d;
            s1_op_q    <= s1_op_d;
            s1_setf_q  <= s1_setf_d;
            s1_rd_q    <= s1_rd_d;
            s2_valid_q <= s2_valid_d;
            res_q      <= res_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            setf_q     <= setf_d;
            n_q        <= n_d;
            z_q        <= z_d;
            c_q        <= c_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_result = res_q;
    assign out_rd     = rd_q;
    assign out_wr     = wr_q;
    assign out_setf   = setf_q;
    assign out_n      = n_q;
    assign out_z      = z_q;
    assign out_c      = c_q;

endmodule

// 32-bit bitwise AND gate cell
module W_AND32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    assign y = a & b;
endmodule

// 32-bit bitwise OR gate cell
module W_OR32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    assign y = a | b;
endmodule

// 32-bit bitwise XOR gate cell
module W_XOR32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    assign y = a ^ b;
endmodule

// File: tb/tb_logic_exec_stage.sv
// tb_logic_exec_stage: self-checking bench for logic_exec_stage.
//   Directed cases plus randomized traffic; every output transfer is
//   compared against a queue of results computed by a behavioural model.
module tb_logic_exec_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [1:0]  in_shtype;
    logic [4:0]  in_shamt;
    logic        in_c;
    logic        in_setf;
    logic [3:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_rd;
    logic        out_wr;
    logic        out_setf;
    logic        out_n;
    logic        out_z;
    logic        out_c;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  rd;
        logic        wr;
        logic        setf;
        logic        n;
        logic        z;
        logic        c;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    logic acc   = 1'b0;

    logic_exec_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .in_shtype(in_shtype), .in_shamt(in_shamt),
        .in_c(in_c), .in_setf(in_setf), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd),
        .out_wr(out_wr), .out_setf(out_setf),
        .out_n(out_n), .out_z(out_z), .out_c(out_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: shift via 64-bit windows, then the op table
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [1:0] st,
                                   input logic [4:0] sh, input logic ci,
                                   input logic sf, input logic [3:0] rd);
        exp_t        m;
        logic [63:0] x;
        logic [31:0] bs;
        logic        c;
        bs = b;
        c  = ci;
        if (sh != 5'd0) begin
            case (st)
                2'd0: begin x = {32'h0, b} << sh; bs = x[31:0];  c = x[32]; end
                2'd1: begin x = {b, 32'h0} >> sh; bs = x[63:32]; c = x[31]; end
                2'd2: begin x = 64'($signed({b, 32'h0}) >>> sh); bs = x[63:32]; c = x[31]; end
                default: begin x = {b, b} >> sh; bs = x[31:0]; c = bs[31]; end
            endcase
        end
        case (op)
            3'd0: m.res = a & bs;
            3'd1: m.res = a ^ bs;
            3'd2: m.res = a | bs;
            3'd3: m.res = a & ~bs;
            3'd4: m.res = bs;
            3'd5: m.res = ~bs;
            3'd6: m.res = a & bs;
            default: m.res = a ^ bs;
        endcase
        m.rd   = rd;
        m.wr   = (op < 3'd6);
        m.setf = sf || (op >= 3'd6);
        m.n    = m.res[31];
        m.z    = (m.res == 32'h0);
        m.c    = c;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_in(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] st, input logic [4:0] sh, input logic c,
                          input logic sf, input logic [3:0] rd);
        in_op = op; in_a = a; in_b = b; in_shtype = st;
        in_shamt = sh; in_c = c; in_setf = sf; in_rd = rd;
    endtask

    // One clock: score handshakes just before the edge, return at the next negedge
    task automatic cyc();
        exp_t e;
        #1;
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            chk("out_expected", 64'(q.size() != 0), 64'(1));
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("xfer", 64'({out_result, out_rd, out_wr, out_setf, out_n, out_z, out_c}), 64'(e));
            end
        end
        if (acc) q.push_back(model(in_op, in_a, in_b, in_shtype, in_shamt, in_c, in_setf, in_rd));
        if (flush) q.delete();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 50 && q.size() != 0; i++) cyc();
        chk(tag, 64'(q.size()), 64'(0));
    endtask

    // Single op with no backpressure: check 2-cycle latency and fixed results
    task automatic run1(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] st, input logic [4:0] sh,
                        input logic c, input logic sf, input logic [31:0] exp_res,
                        input logic [4:0] exp_fl);
        out_ready = 1'b1;
        set_in(op, a, b, st, sh, c, sf, 4'd5);
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk({tag, "_lat1"}, 64'(out_valid), 64'(0));
        cyc();
        chk({tag, "_lat2"}, 64'(out_valid), 64'(1));
        chk({tag, "_res"}, 64'(out_result), 64'(exp_res));
        chk({tag, "_flags"}, 64'({out_wr, out_setf, out_n, out_z, out_c}), 64'(exp_fl));
        cyc();
    endtask

    initial begin
        logic [31:0] hold_res;
        logic [2:0]  bp_op [4];
        int          nacc;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_in(3'd0, 32'h0, 32'h0, 2'd0, 5'd0, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        #1;
        chk("rst_outs", 64'({out_valid, out_result, out_rd, out_wr, out_setf, out_n, out_z, out_c}), 64'(0));
        rst = 1'b0;
        #1;
        chk("rst_ready", 64'(in_ready), 64'(1));
        @(negedge clk);

        // Directed ops: {wr,setf,n,z,c}
        run1("and",  3'd0, 32'hF0F0_0000, 32'h0FF0_0000, 2'd0, 5'd0, 1'b1, 1'b1, 32'h00F0_0000, 5'b11001);
        run1("lsr1", 3'd4, 32'h0,         32'h8000_0001, 2'd1, 5'd1, 1'b0, 1'b1, 32'h4000_0000, 5'b11001);
        run1("asr1", 3'd4, 32'h0,         32'h8000_0001, 2'd2, 5'd1, 1'b0, 1'b1, 32'hC000_0000, 5'b11101);
        run1("ror4", 3'd4, 32'h0,         32'h0000_000F, 2'd3, 5'd4, 1'b0, 1'b1, 32'hF000_0000, 5'b11101);
        run1("lsl1", 3'd4, 32'h0,         32'h8000_0001, 2'd0, 5'd1, 1'b0, 1'b1, 32'h0000_0002, 5'b11001);
        run1("tst",  3'd6, 32'h1234_5678, 32'hEDCB_A987, 2'd0, 5'd0, 1'b0, 1'b0, 32'h0000_0000, 5'b01010);
        run1("teq",  3'd7, 32'h1234_5678, 32'hEDCB_A987, 2'd0, 5'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 5'b01100);

        // Backpressure: four ops against a stalled output
        bp_op[0] = 3'd1; bp_op[1] = 3'd2; bp_op[2] = 3'd3; bp_op[3] = 3'd5;
        nacc = 0;
        hold_res = 32'h0;
        out_ready = 1'b0;
        set_in(bp_op[0], $urandom, $urandom, 2'($urandom), 5'($urandom), 1'($urandom), 1'b1, 4'd1);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (acc) begin
                nacc++;
                set_in(bp_op[nacc], $urandom, $urandom, 2'($urandom), 5'($urandom), 1'($urandom), 1'b1, 4'(nacc + 1));
            end
            if (i == 1) hold_res = out_result;
        end
        chk("bp_accepts", 64'(nacc), 64'(2));
        chk("bp_ready", 64'(in_ready), 64'(0));
        chk("bp_hold", 64'(out_result), 64'(hold_res));
        out_ready = 1'b1;
        for (int i = 0; i < 20 && nacc < 4; i++) begin
            cyc();
            if (acc) begin
                nacc++;
                if (nacc < 4)
                    set_in(bp_op[nacc], $urandom, $urandom, 2'($urandom), 5'($urandom), 1'($urandom), 1'b1, 4'(nacc + 1));
                else
                    in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("bp_all_accepted", 64'(nacc), 64'(4));
        drain("bp_drain");

        // Flush with two ops in flight and output stalled
        out_ready = 1'b0;
        set_in(3'd1, $urandom, $urandom, 2'd0, 5'd3, 1'b0, 1'b1, 4'd7);
        in_valid = 1'b1;
        cyc();
        set_in(3'd2, $urandom, $urandom, 2'd1, 5'd2, 1'b0, 1'b1, 4'd8);
        cyc();
        in_valid = 1'b0;
        chk("fl_pre_valid", 64'(out_valid), 64'(1));
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        #1;
        chk("fl_valid", 64'(out_valid), 64'(0));
        chk("fl_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        out_ready = 1'b1;
        set_in(3'd3, 32'hFFFF_0000, 32'h0F0F_0F0F, 2'd0, 5'd0, 1'b1, 1'b1, 4'd9);
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        chk("fl_new_valid", 64'(out_valid), 64'(1));
        chk("fl_new_res", 64'(out_result), 64'(32'hF0F0_0000));
        chk("fl_alone", 64'(q.size()), 64'(1));
        cyc();
        chk("fl_after", 64'(out_valid), 64'(0));

        // Async reset between edges with the pipeline full
        out_ready = 1'b0;
        set_in(3'd5, 32'h0, 32'h1234_0000, 2'd0, 5'd0, 1'b0, 1'b1, 4'd2);
        in_valid = 1'b1;
        cyc();
        cyc();
        in_valid = 1'b0;
        chk("ar_pre_valid", 64'(out_valid), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", 64'(out_valid), 64'(0));
        chk("ar_result", 64'(out_result), 64'(0));
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ar_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        run1("ar_new", 3'd2, 32'h0000_00F0, 32'h0000_000F, 2'd0, 5'd4, 1'b0, 1'b0, 32'h0000_00F0, 5'b10000);

        // Randomized traffic with backpressure and occasional flush
        in_valid = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 9) < 7);
                set_in(3'($urandom), $urandom, $urandom, 2'($urandom), 5'($urandom),
                       1'($urandom), 1'($urandom), 4'($urandom));
            end
            out_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 29) == 0);
            cyc();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain("rand_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
